// File: rtl/clk_enable_gen.sv
// Lock sequencer and clock-enable generator for the 448 MHz PLL domain.
// Holds the emulation in reset until the PLL has been locked for RST_HOLD cycles, then emits CPU/pixel/audio enables.
module clk_enable_gen #(
    parameter int CPU_DIV  = 224,
    parameter int PIX_DIV  = 56,
    parameter int AUD_DIV  = 448,
    parameter int RST_HOLD = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic [1:0] cpu_speed,
    output logic       sys_rst_n,
    output logic       cpu_ce,
    output logic       pix_ce,
    output logic       aud_ce,
    output logic       running
);

    localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD - 1);
    localparam logic [15:0]   CPU_BASE  = 16'(CPU_DIV);
    localparam logic [15:0]   PIX_LAST  = 16'(PIX_DIV - 1);
    localparam logic [15:0]   AUD_LAST  = 16'(AUD_DIV - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        RUN  = 2'd2
    } state_t;

    logic          sync1_q, sync2_q;
    state_t        state_q, state_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic [1:0]    speed_pend_q;
    logic [15:0]   cpu_div_q, cpu_div_d;
    logic [15:0]   cpu_cnt_q, cpu_cnt_d;
    logic [15:0]   pix_cnt_q, pix_cnt_d;
    logic [15:0]   aud_cnt_q, aud_cnt_d;
    logic          cpu_ce_q, cpu_ce_d;
    logic          pix_ce_q, pix_ce_d;
    logic          aud_ce_q, aud_ce_d;
    logic          sys_rst_n_q, sys_rst_n_d;

    logic run_d, stay_run, cpu_wrap, pix_wrap, aud_wrap;

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            IDLE: begin
                hold_cnt_d = '0;
                if (sync2_q) state_d = HOLD;
            end
            HOLD: begin
                if (!sync2_q)                   state_d = IDLE;
                else if (hold_cnt_q == HOLD_LAST) state_d = RUN;
                else                            hold_cnt_d = hold_cnt_q + 1'b1;
            end
            RUN: begin
                if (!sync2_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Counters restart from 0 on RUN entry, so a period cut short by lock loss is discarded.
    always_comb begin
        run_d    = (state_d == RUN);
        stay_run = run_d && (state_q == RUN);
        cpu_wrap = (cpu_cnt_q == cpu_div_q - 16'd1);
        pix_wrap = (pix_cnt_q == PIX_LAST);
        aud_wrap = (aud_cnt_q == AUD_LAST);

        cpu_div_d = cpu_div_q;
        if (run_d && ((state_q != RUN) || cpu_wrap))
            cpu_div_d = CPU_BASE >> speed_pend_q;

        cpu_cnt_d = (stay_run && !cpu_wrap) ? cpu_cnt_q + 16'd1 : 16'd0;
        pix_cnt_d = (stay_run && !pix_wrap) ? pix_cnt_q + 16'd1 : 16'd0;
        aud_cnt_d = (stay_run && !aud_wrap) ? aud_cnt_q + 16'd1 : 16'd0;

        cpu_ce_d    = run_d && (cpu_cnt_d == cpu_div_d - 16'd1);
        pix_ce_d    = run_d && (pix_cnt_d == PIX_LAST);
        aud_ce_d    = run_d && (aud_cnt_d == AUD_LAST);
        sys_rst_n_d = run_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            state_q      <= IDLE;
            hold_cnt_q   <= '0;
            speed_pend_q <= 2'd0;
            cpu_div_q    <= CPU_BASE;
            cpu_cnt_q    <= 16'd0;
            pix_cnt_q    <= 16'd0;
            aud_cnt_q    <= 16'd0;
            cpu_ce_q     <= 1'b0;
            pix_ce_q     <= 1'b0;
            aud_ce_q     <= 1'b0;
            sys_rst_n_q  <= 1'b0;
        end else begin
            sync1_q      <= pll_locked;
            sync2_q      <= sync1_q;
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            speed_pend_q <= cpu_speed;
            cpu_div_q    <= cpu_div_d;
            cpu_cnt_q    <= cpu_cnt_d;
            pix_cnt_q    <= pix_cnt_d;
            aud_cnt_q    <= aud_cnt_d;
            cpu_ce_q     <= cpu_ce_d;
            pix_ce_q     <= pix_ce_d;
            aud_ce_q     <= aud_ce_d;
            sys_rst_n_q  <= sys_rst_n_d;
        end
    end

    assign sys_rst_n = sys_rst_n_q;
    assign running   = sys_rst_n_q;
    assign cpu_ce    = cpu_ce_q;
    assign pix_ce    = pix_ce_q;
    assign aud_ce    = aud_ce_q;

endmodule
